// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation, ROM fetch and a small {pc, inst, adef} queue toward decode
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   o_rom_inst_en/_addr      ROM read enable and byte address (address is the pc register)
//   i_rom_inst               ROM data, valid in the same cycle as the address
//   i_redirect_en/_pc        branch/exception redirect: flushes the queue, reloads pc
//   i_fetch_pause            stop fetching while the queue keeps draining
//   i_id_ready, o_id_*       valid/ready handshake presenting the queue head to decode
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          ADDR_W      = 32,
  parameter int          INST_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rom_inst_en,
  output logic [ADDR_W-1:0] o_rom_inst_addr,
  input  logic [INST_W-1:0] i_rom_inst,
  input  logic              i_redirect_en,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_fetch_pause,
  input  logic              i_id_ready,
  output logic              o_id_valid,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [INST_W-1:0] o_id_inst,
  output logic              o_id_excp_adef
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  typedef enum logic {RUN, EXC_WAIT} state_t;
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [PW:0]         r_count;
  logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [ADDR_W-1:0]   r_q_pc   [QUEUE_DEPTH];
  logic [INST_W-1:0]   r_q_inst [QUEUE_DEPTH];
  logic                r_q_adef [QUEUE_DEPTH];
  logic                w_fetch_go, w_aligned, w_push, w_pop, w_valid;
  assign w_aligned  = r_pc[1:0] == 2'b00;
  // Full test uses the count at cycle start, so a same-cycle pop never frees a slot
  assign w_fetch_go = !rst && r_state == RUN && !i_redirect_en && !i_fetch_pause &&
                      r_count < (PW+1)'(QUEUE_DEPTH);
  assign w_push     = w_fetch_go;
  assign w_valid    = !rst && r_count != '0;
  assign w_pop      = i_id_ready && w_valid;
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_en) w_state_nxt = RUN;
    else if (w_fetch_go && !w_aligned) w_state_nxt = EXC_WAIT;
  end
  always_comb begin
    o_rom_inst_en   = w_fetch_go && w_aligned;
    o_rom_inst_addr = r_pc;
    o_id_valid      = w_valid;
    o_id_pc         = w_valid ? r_q_pc[r_rd_ptr]   : '0;
    o_id_inst       = w_valid ? r_q_inst[r_rd_ptr] : '0;
    o_id_excp_adef  = w_valid ? r_q_adef[r_rd_ptr] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC[ADDR_W-1:0];
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_redirect_en) begin
      r_pc     <= i_redirect_pc;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_pc     <= (w_push && w_aligned) ? r_pc + ADDR_W'(4) : r_pc;
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // A misaligned pc is queued with a zero instruction and the fault tag
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_inst[r_wr_ptr] <= w_aligned ? i_rom_inst : '0;
      r_q_adef[r_wr_ptr] <= !w_aligned;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch, queue, redirect, fault tagging and reset
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [31:0] rom_addr, rom_inst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fetch_pause, id_ready, id_valid, id_adef;
  logic [31:0] id_pc, id_inst;
  int          n_checks = 0;
  int          n_errors = 0;
  always #5 clk = ~clk;
  assign rom_inst = rom_en ? ~rom_addr : 32'h0;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .o_rom_inst_en(rom_en), .o_rom_inst_addr(rom_addr), .i_rom_inst(rom_inst),
    .i_redirect_en(redirect_en), .i_redirect_pc(redirect_pc), .i_fetch_pause(fetch_pause),
    .i_id_ready(id_ready), .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst),
    .o_id_excp_adef(id_adef)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; fetch_pause = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(id_valid), 0);
      chk("rst_rom_en", 32'(rom_en), 0);
    end
    rst = 1'b0; id_ready = 1'b1; #1;
    chk("boot_addr", rom_addr, 32'h1c000000);
    chk("boot_en", 32'(rom_en), 1);
    chk("boot_valid", 32'(id_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_pc", id_pc, 32'h1c000000 + 32'(4*i));
      chk("stream_inst", id_inst, ~(32'h1c000000 + 32'(4*i)));
    end
    redirect_en = 1'b1; redirect_pc = 32'h1c000000; id_ready = 1'b0;
    tick();
    redirect_en = 1'b0; #1;
    chk("flush_valid", 32'(id_valid), 0);
    for (int i = 0; i < 8; i++) tick();
    chk("full_rom_en", 32'(rom_en), 0);
    chk("full_pc_hold", rom_addr, 32'h1c000010);
    chk("full_head", id_pc, 32'h1c000000);
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_pc", id_pc, 32'h1c000000 + 32'(4*i));
    end
    chk("drain_inst", id_inst, ~32'h1c000010);
    id_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("refill_rom_en", 32'(rom_en), 0);
    chk("refill_valid", 32'(id_valid), 1);
    redirect_en = 1'b1; redirect_pc = 32'h1c000200; id_ready = 1'b1;
    tick();
    redirect_en = 1'b0; #1;
    chk("redir_valid0", 32'(id_valid), 0);
    chk("redir_addr", rom_addr, 32'h1c000200);
    chk("redir_rom_en", 32'(rom_en), 1);
    tick();
    chk("redir_valid1", 32'(id_valid), 1);
    chk("redir_pc", id_pc, 32'h1c000200);
    redirect_en = 1'b1; redirect_pc = 32'h1c000102; id_ready = 1'b0;
    tick();
    redirect_en = 1'b0; #1;
    chk("mis_rom_en", 32'(rom_en), 0);
    chk("mis_addr", rom_addr, 32'h1c000102);
    tick();
    chk("adef_valid", 32'(id_valid), 1);
    chk("adef_pc", id_pc, 32'h1c000102);
    chk("adef_flag", 32'(id_adef), 1);
    chk("adef_inst", id_inst, 0);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exc_wait_en", 32'(rom_en), 0);
      chk("exc_wait_valid", 32'(id_valid), 0);
    end
    redirect_en = 1'b1; redirect_pc = 32'h1c000300; fetch_pause = 1'b1; id_ready = 1'b0;
    tick();
    redirect_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("pause_rom_en", 32'(rom_en), 0);
      chk("pause_addr", rom_addr, 32'h1c000300);
      tick();
    end
    fetch_pause = 1'b0; #1;
    chk("unpause_en", 32'(rom_en), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_valid", 32'(id_valid), 1);
    chk("pre_rst_head", id_pc, 32'h1c000300);
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h1c000500; id_ready = 1'b1; #1;
    chk("rst_hold_valid", 32'(id_valid), 0);
    chk("rst_hold_pc", id_pc, 0);
    chk("rst_hold_en", 32'(rom_en), 0);
    tick();
    rst = 1'b0; redirect_en = 1'b0; id_ready = 1'b0; #1;
    chk("post_rst_valid", 32'(id_valid), 0);
    chk("post_rst_addr", rom_addr, 32'h1c000000);
    chk("post_rst_en", 32'(rom_en), 1);
    tick();
    chk("post_rst_pc", id_pc, 32'h1c000000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
